// File: rtl/if_fetch_requester.sv
// Instruction-fetch initiator: sequential req/gnt fetches, in-order response FIFO,
// valid/ready delivery to the fetch stage, and branch redirect with in-flight discard.
module if_fetch_requester #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, REQ} state_e;

  state_e        state;
  logic          req_q;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, discard, fifo_cnt;
  logic          pend_br;
  logic [31:0]   pend_tgt;

  logic [31:0]   aq_addr [FIFO_DEPTH];
  logic [PW-1:0] aq_wp, aq_rp;

  logic [31:0]   f_data [FIFO_DEPTH];
  logic [31:0]   f_addr [FIFO_DEPTH];
  logic          f_err  [FIFO_DEPTH];
  logic [PW-1:0] f_wp, f_rp;

  logic          gnt_acc, drop, push, pop, credit_now, credit_next;
  logic [CW-1:0] out_next, cnt_next, discard_next;
  logic [31:0]   pc_next, br_tgt;
  logic          unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign unused_bits = ^branch_addr_i[1:0];
  assign br_tgt      = {branch_addr_i[31:2], 2'b00};

  assign gnt_acc  = req_q & instr_gnt_i;
  // A response arriving in the redirect cycle belongs to the old stream.
  assign drop     = instr_rvalid_i & (branch_i | (discard != '0));
  assign push     = instr_rvalid_i & ~drop;
  assign pop      = fetch_valid_o & fetch_ready_i & ~branch_i;
  assign out_next = outstanding + CW'(gnt_acc) - CW'(instr_rvalid_i);
  assign cnt_next = branch_i ? '0 : fifo_cnt + CW'(push) - CW'(pop);

  assign credit_now  = ({1'b0, outstanding} + {1'b0, fifo_cnt}) < DEPTH_C;
  assign credit_next = ({1'b0, out_next} + {1'b0, cnt_next}) < DEPTH_C;

  always_comb begin
    pc_next = pc;
    if (gnt_acc) pc_next = pend_br ? pend_tgt : pc + 32'd4;
    if (branch_i && (!req_q || instr_gnt_i)) pc_next = br_tgt;
  end

  // A deferred redirect counts its own held request as stale once granted.
  always_comb begin
    if (branch_i) discard_next = out_next;
    else discard_next = discard - CW'(instr_rvalid_i && (discard != '0))
                                + CW'(gnt_acc && pend_br);
  end

  assign instr_req_o   = req_q;
  assign instr_addr_o  = pc;
  assign fetch_valid_o = (fifo_cnt != '0);
  assign fetch_rdata_o = f_data[f_rp];
  assign fetch_addr_o  = f_addr[f_rp];
  assign fetch_err_o   = f_err[f_rp];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      pc          <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
      fifo_cnt    <= '0;
      pend_br     <= 1'b0;
      pend_tgt    <= '0;
      aq_wp       <= '0;
      aq_rp       <= '0;
      f_wp        <= '0;
      f_rp        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        aq_addr[i] <= '0;
        f_data[i]  <= '0;
        f_addr[i]  <= '0;
        f_err[i]   <= 1'b0;
      end
    end else begin
      pc          <= pc_next;
      outstanding <= out_next;
      discard     <= discard_next;
      fifo_cnt    <= cnt_next;

      case (state)
        IDLE: if (fetch_en_i && credit_now) begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: if (gnt_acc && !(fetch_en_i && credit_next)) begin
          state <= IDLE;
          req_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase

      if (branch_i && req_q && !instr_gnt_i) begin
        pend_br  <= 1'b1;
        pend_tgt <= br_tgt;
      end else if (gnt_acc) begin
        pend_br  <= 1'b0;
      end

      if (gnt_acc) begin
        aq_addr[aq_wp] <= pc;
        aq_wp          <= ptr_inc(aq_wp);
      end
      if (instr_rvalid_i) aq_rp <= ptr_inc(aq_rp);

      if (branch_i) begin
        f_wp <= '0;
        f_rp <= '0;
      end else begin
        if (push) begin
          f_data[f_wp] <= instr_rdata_i;
          f_addr[f_wp] <= aq_addr[aq_rp];
          f_err[f_wp]  <= instr_err_i;
          f_wp         <= ptr_inc(f_wp);
        end
        if (pop) f_rp <= ptr_inc(f_rp);
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   instr_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_if_fetch_requester.sv
// Randomized bench: memory responder + stream-level reference model feeding a
// scoreboard queue; a negedge monitor pops and compares every fetch handshake.
module tb_if_fetch_requester;

  localparam logic [31:0] BOOT  = 32'h0000_0080;
  localparam int unsigned DEPTH = 2;

  logic        clk, rst_ni;
  logic        fetch_en_i, branch_i, fetch_ready_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o, fetch_err_o;
  logic [31:0] fetch_rdata_o, fetch_addr_o;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_addr_o, instr_rdata_i;

  if_fetch_requester #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i), .fetch_rdata_o(fetch_rdata_o),
    .fetch_addr_o(fetch_addr_o), .fetch_err_o(fetch_err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          tag;
    int unsigned due;
    logic        err;
  } mem_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } item_t;

  mem_t  mem_q[$];
  item_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int unsigned p_gnt, p_br, p_ready, p_en, lat_max, cyc;
  logic        force_br;
  logic [31:0] force_tgt;
  logic [31:0] exp_pc;
  int          epoch;
  logic        stale, prev_req, prev_gnt, prev_en, deliv_prev, mon_en;
  logic [31:0] prev_addr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h0013, ~a[31:16]};
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(3) == 0) t[31:8] = '1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    sb_q.delete();
    exp_pc     = BOOT;
    epoch++;
    stale      = 1'b0;
    prev_req   = 1'b0;
    prev_gnt   = 1'b0;
    prev_en    = fetch_en_i;
    prev_addr  = BOOT;
    deliv_prev = 1'b0;
  endtask

  // One cycle: check the post-edge outputs, then choose and drive the next inputs.
  task automatic step();
    mem_t        m;
    item_t       it;
    logic        g, br, rv, en, rdy, dlv;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_req && !prev_gnt)
      chk("req_hold", 128'({instr_req_o, instr_addr_o}), 128'({1'b1, prev_addr}));
    else if (instr_req_o)
      chk("req_needs_en", 128'(prev_en), 128'(1'b1));
    chk("credit", 128'(mem_q.size() + sb_q.size() <= DEPTH), 128'(1'b1));
    if (deliv_prev) chk("rvalid_latency", 128'(fetch_valid_o), 128'(1'b1));

    br  = force_br || ($urandom_range(99) < p_br);
    tgt = force_br ? force_tgt : rand_tgt();
    force_br = 1'b0;
    g   = instr_req_o && ($urandom_range(99) < p_gnt);
    en  = $urandom_range(99) < p_en;
    rdy = $urandom_range(99) < p_ready;
    rv  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    dlv = 1'b0;

    if (rv) begin
      m   = mem_q.pop_front();
      dlv = !br && (m.tag == epoch);
      instr_rdata_i = data_of(m.addr);
      instr_err_i   = m.err;
      if (dlv) begin
        it.addr = m.addr;
        it.data = data_of(m.addr);
        it.err  = m.err;
        sb_q.push_back(it);
      end
    end else begin
      instr_rdata_i = $urandom;
      instr_err_i   = $urandom_range(1) == 1;
    end

    if (g) begin
      m.addr = instr_addr_o;
      m.err  = ($urandom_range(7) == 0);
      m.due  = cyc + 1 + $urandom_range(lat_max);
      if (stale) begin
        m.tag = -1;
        stale = 1'b0;
      end else begin
        chk("req_addr", 128'(instr_addr_o), 128'(exp_pc));
        exp_pc = exp_pc + 32'd4;
        m.tag  = br ? -1 : epoch;
      end
      mem_q.push_back(m);
    end

    if (br) begin
      epoch++;
      sb_q.delete();
      if (instr_req_o && !g) stale = 1'b1;
      exp_pc = {tgt[31:2], 2'b00};
    end

    branch_i       = br;
    branch_addr_i  = tgt;
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    fetch_en_i     = en;
    fetch_ready_i  = rdy;
    prev_req   = instr_req_o;
    prev_gnt   = g;
    prev_addr  = instr_addr_o;
    prev_en    = en;
    deliv_prev = dlv;
  endtask

  always @(negedge clk) begin
    item_t e;
    if (mon_en && rst_ni && fetch_valid_o && fetch_ready_i && !branch_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_fetch", 128'(fetch_addr_o), 128'(32'hDEAD_BEEF));
      end else begin
        e = sb_q.pop_front();
        chk("fetch_head", 128'({fetch_addr_o, fetch_rdata_o, fetch_err_o}),
            128'({e.addr, e.data, e.err}));
      end
    end
  end

  localparam logic [127:0] RESET_VEC = 128'({1'b0, BOOT, 1'b0, 32'h0, 32'h0, 1'b0});

  initial begin
    int unsigned n;
    rst_ni = 1'b0; mon_en = 1'b0; cyc = 0; epoch = 0; force_br = 1'b0; force_tgt = '0;
    fetch_en_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0; fetch_ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", 128'({instr_req_o, instr_addr_o, fetch_valid_o,
        fetch_rdata_o, fetch_addr_o, fetch_err_o}), RESET_VEC);
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Immediate grants, 1-cycle responses, consumer stalled: FIFO fills, requests stop.
    p_gnt = 100; p_br = 0; p_ready = 0; p_en = 100; lat_max = 0;
    repeat (8) step();
    chk("full_stall", 128'({sb_q.size() == 2, instr_req_o, fetch_valid_o, fetch_addr_o,
        fetch_rdata_o}), 128'({1'b1, 1'b0, 1'b1, BOOT, data_of(BOOT)}));

    p_gnt = 60; p_br = 5; p_ready = 70; p_en = 90; lat_max = 3;
    repeat (3000) step();

    // Redirect to the top word: the next request must wrap to zero.
    p_gnt = 100; p_br = 0; p_ready = 100; p_en = 100; lat_max = 0;
    force_br = 1'b1; force_tgt = 32'hFFFF_FFFC;
    repeat (12) step();

    p_en = 0;
    n = 0;
    while (n < 200 && (instr_req_o || mem_q.size() != 0 || sb_q.size() != 0)) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("drain", 128'({sb_q.size() == 0, mem_q.size() == 0, fetch_valid_o, instr_req_o}),
        128'({1'b1, 1'b1, 1'b0, 1'b0}));

    p_gnt = 50; p_br = 3; p_ready = 40; p_en = 100; lat_max = 2;
    repeat (40) step();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midstream_reset", 128'({instr_req_o, instr_addr_o, fetch_valid_o,
        fetch_rdata_o, fetch_addr_o, fetch_err_o}), RESET_VEC);
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; branch_i = 1'b0; fetch_en_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
